// File: rtl/time_init_sequencer.sv
// Time-scale init sequencer: latches a requested time set, waits a programmable
// number of epoch pulses, then holds the init-write flags for exactly one load epoch.
// Optional PPS alignment (WAIT_PPS state, pps_align/sec_pulse ports) under TIME_INIT_PPS_ALIGN_EN.
module time_init_sequencer #(
  parameter  int unsigned DLY_WIDTH = 8,
  localparam int unsigned CP_W      = 32,
  localparam int unsigned CHIP_W    = 24,
  localparam int unsigned SYMB_W    = 5,
  localparam int unsigned EPOCH_W   = 10,
  localparam int unsigned TOW_W     = 20
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 cancel,
  input  logic [DLY_WIDTH-1:0] epoch_dly,
  input  logic [2:0]           load_mask,
  input  logic [CP_W-1:0]      code_phase_in,
  input  logic [CHIP_W-1:0]    chip_in,
  input  logic [SYMB_W-1:0]    symb_in,
  input  logic [EPOCH_W-1:0]   epoch_in,
  input  logic [TOW_W-1:0]     tow_in,
`ifdef TIME_INIT_PPS_ALIGN_EN
  input  logic                 pps_align,
  input  logic                 sec_pulse,
`endif
  input  logic                 epoch_pulse,
  output logic                 ack,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state,
  output logic                 code_phase_init_wr,
  output logic                 chip_and_symb_init_wr,
  output logic                 epoch_and_tow_init_wr,
  output logic [CP_W-1:0]      code_phase_init,
  output logic [CHIP_W-1:0]    chip_counter_init,
  output logic [SYMB_W-1:0]    symb_counter_init,
  output logic [EPOCH_W-1:0]   epoch_counter_init,
  output logic [TOW_W-1:0]     tow_counter_init
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    LOAD     = 2'd2,
    WAIT_PPS = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DLY_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           mask_q;
  logic [2:0]           flags_d;
  logic                 ack_d, done_d, busy_d, accept;

  assign state = state_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          ack_d   = 1'b1;
          cnt_d   = epoch_dly;
          state_d = ARMED;
`ifdef TIME_INIT_PPS_ALIGN_EN
          if (pps_align) state_d = WAIT_PPS;
`endif
        end
      end
      WAIT_PPS: begin
`ifdef TIME_INIT_PPS_ALIGN_EN
        // cnt still holds the latched delay; it is not touched while waiting
        if (cancel)         state_d = IDLE;
        else if (sec_pulse) state_d = ARMED;
`else
        state_d = IDLE;
`endif
      end
      ARMED: begin
        // The pulse seen during the ack cycle belongs to the acceptance and is not counted
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = LOAD;
        end else if (epoch_pulse && !ack) begin
          cnt_d = cnt_q - DLY_WIDTH'(1);
          if (cnt_q == DLY_WIDTH'(1)) state_d = LOAD;
        end
      end
      LOAD: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (epoch_pulse) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    flags_d = (state_d == LOAD) ? mask_q : 3'b000;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      mask_q                <= 3'b000;
      ack                   <= 1'b0;
      done                  <= 1'b0;
      busy                  <= 1'b0;
      code_phase_init_wr    <= 1'b0;
      chip_and_symb_init_wr <= 1'b0;
      epoch_and_tow_init_wr <= 1'b0;
      code_phase_init       <= '0;
      chip_counter_init     <= '0;
      symb_counter_init     <= '0;
      epoch_counter_init    <= '0;
      tow_counter_init      <= '0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      ack                   <= ack_d;
      done                  <= done_d;
      busy                  <= busy_d;
      code_phase_init_wr    <= flags_d[0];
      chip_and_symb_init_wr <= flags_d[1];
      epoch_and_tow_init_wr <= flags_d[2];
      if (accept) begin
        mask_q             <= load_mask;
        code_phase_init    <= code_phase_in;
        chip_counter_init  <= chip_in;
        symb_counter_init  <= symb_in;
        epoch_counter_init <= epoch_in;
        tow_counter_init   <= tow_in;
      end
    end
  end

endmodule

// File: tb/tb_time_init_sequencer.sv
// Randomised bench for time_init_sequencer with an epoch-counting reference model
// and directed scenarios; PPS scenarios only when TIME_INIT_PPS_ALIGN_EN is defined.
module tb_time_init_sequencer;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, cancel = 1'b0, epoch_pulse = 1'b0;
  logic        pps_align = 1'b0, sec_pulse = 1'b0;
  logic [7:0]  epoch_dly = '0;
  logic [2:0]  load_mask = '0;
  logic [31:0] code_phase_in = '0;
  logic [23:0] chip_in = '0;
  logic [4:0]  symb_in = '0;
  logic [9:0]  epoch_in = '0;
  logic [19:0] tow_in = '0;

  logic        ack, busy, done;
  logic [1:0]  state;
  logic        cp_wr, cs_wr, et_wr;
  logic [31:0] code_phase_init;
  logic [23:0] chip_counter_init;
  logic [4:0]  symb_counter_init;
  logic [9:0]  epoch_counter_init;
  logic [19:0] tow_counter_init;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef TIME_INIT_PPS_ALIGN_EN
  localparam bit PPS_EN = 1'b1;
`else
  localparam bit PPS_EN = 1'b0;
`endif

  time_init_sequencer dut (
    .pclk(pclk), .reset(reset), .req(req), .cancel(cancel),
    .epoch_dly(epoch_dly), .load_mask(load_mask),
    .code_phase_in(code_phase_in), .chip_in(chip_in), .symb_in(symb_in),
    .epoch_in(epoch_in), .tow_in(tow_in),
`ifdef TIME_INIT_PPS_ALIGN_EN
    .pps_align(pps_align), .sec_pulse(sec_pulse),
`endif
    .epoch_pulse(epoch_pulse),
    .ack(ack), .busy(busy), .done(done), .state(state),
    .code_phase_init_wr(cp_wr), .chip_and_symb_init_wr(cs_wr),
    .epoch_and_tow_init_wr(et_wr),
    .code_phase_init(code_phase_init), .chip_counter_init(chip_counter_init),
    .symb_counter_init(symb_counter_init), .epoch_counter_init(epoch_counter_init),
    .tow_counter_init(tow_counter_init)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a load is pending until enough epoch pulses have been seen
  // strictly after the arming origin; the load epoch is the next pulse after that.
  int          cyc = 0;
  bit          m_busy = 0, m_wait = 0, m_in_load = 0;
  int          m_dly = 0, m_seen = 0, m_origin = 0, m_earliest = 0;
  logic [2:0]  m_mask = '0;
  logic [90:0] m_vals = '0;
  logic        e_ack, e_done;
  logic [1:0]  e_state;

  always @(posedge pclk) begin
    cyc++;
    e_ack  = 1'b0;
    e_done = 1'b0;
    if (reset) begin
      m_busy = 0; m_wait = 0; m_vals = '0; m_mask = '0;
    end else if (!m_busy) begin
      if (req) begin
        m_busy     = 1;
        e_ack      = 1'b1;
        m_vals     = {code_phase_in, chip_in, symb_in, epoch_in, tow_in};
        m_mask     = load_mask;
        m_dly      = int'(epoch_dly);
        m_seen     = 0;
        m_wait     = PPS_EN && pps_align;
        m_origin   = cyc;
        m_earliest = cyc + 1;
      end
    end else if (cancel) begin
      m_busy = 0;
    end else if (m_wait) begin
      if (sec_pulse) begin
        m_wait     = 0;
        m_origin   = cyc - 1;
        m_earliest = cyc + 1;
        m_seen     = 0;
      end
    end else if (epoch_pulse) begin
      if (m_in_load) begin
        e_done = 1'b1;
        m_busy = 0;
      end else if (cyc - 1 > m_origin) begin
        m_seen++;
      end
    end
    m_in_load = m_busy && !m_wait && (cyc >= m_earliest) && (m_seen >= m_dly);
    e_state   = !m_busy ? 2'd0 : m_wait ? 2'd3 : m_in_load ? 2'd2 : 2'd1;
    #1;
    chk("ack", 128'(ack), 128'(e_ack));
    chk("done", 128'(done), 128'(e_done));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("state", 128'(state), 128'(e_state));
    chk("flags", 128'({et_wr, cs_wr, cp_wr}), 128'(m_in_load ? m_mask : 3'b000));
    chk("init_values", 128'({code_phase_init, chip_counter_init, symb_counter_init,
                             epoch_counter_init, tow_counter_init}), 128'(m_vals));
  end

  task automatic cycle();
    @(posedge pclk);
    #2;
  endtask

  task automatic request(input logic [7:0] dly, input logic [2:0] mask, input logic [31:0] cp);
    req = 1'b1; epoch_dly = dly; load_mask = mask; code_phase_in = cp;
    chip_in = 24'hA5A5A5; symb_in = 5'd17; epoch_in = 10'd999; tow_in = 20'd12345;
  endtask

  initial begin
    repeat (3) cycle();
    chk("reset_state", 128'(state), 128'(0));
    chk("reset_flags", 128'({et_wr, cs_wr, cp_wr}), 128'(0));
    reset = 1'b0;
    cycle();

    // Immediate load, all flags
    request(8'd0, 3'b111, 32'h1234_5678);
    cycle(); req = 1'b0;
    chk("t1_ack", 128'(ack), 128'(1));
    chk("t1_cp_init", 128'(code_phase_init), 128'(32'h1234_5678));
    cycle();
    chk("t1_flags", 128'({et_wr, cs_wr, cp_wr}), 128'(3'b111));
    repeat (3) cycle();
    epoch_pulse = 1'b1; cycle(); epoch_pulse = 1'b0;
    chk("t1_done", 128'(done), 128'(1));
    chk("t1_flags_low", 128'({et_wr, cs_wr, cp_wr}), 128'(0));
    cycle();

    // Delay 3, epoch/TOW only; pulses in acceptance and ack cycles not counted
    request(8'd3, 3'b100, 32'h0);
    tow_in = 20'd604799;
    epoch_pulse = 1'b1;
    cycle(); req = 1'b0;
    cycle(); epoch_pulse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (2) cycle();
      epoch_pulse = 1'b1; cycle(); epoch_pulse = 1'b0;
      if (i == 1) chk("t2_not_yet", 128'(et_wr), 128'(0));
      if (i == 2) chk("t2_flags", 128'({et_wr, cs_wr, cp_wr}), 128'(3'b100));
      if (i == 3) begin
        chk("t2_done", 128'(done), 128'(1));
        chk("t2_tow", 128'(tow_counter_init), 128'(20'd604799));
      end
    end
    cycle();

    // Cancel beats the load epoch
    request(8'd0, 3'b111, 32'h1);
    cycle(); req = 1'b0;
    repeat (2) cycle();
    cancel = 1'b1; epoch_pulse = 1'b1; cycle(); cancel = 1'b0; epoch_pulse = 1'b0;
    chk("t3_no_done", 128'(done), 128'(0));
    chk("t3_state", 128'(state), 128'(0));
    cycle();

    // Request while armed is ignored
    request(8'd2, 3'b011, 32'hCAFE_0001);
    cycle(); req = 1'b0;
    cycle();
    request(8'd0, 3'b001, 32'hDEAD_BEEF);
    cycle(); req = 1'b0;
    chk("t4_no_ack", 128'(ack), 128'(0));
    chk("t4_cp_kept", 128'(code_phase_init), 128'(32'hCAFE_0001));
    cancel = 1'b1; cycle(); cancel = 1'b0;
    cycle();

    // Reset in LOAD
    request(8'd0, 3'b111, 32'h5555_AAAA);
    cycle(); req = 1'b0;
    repeat (2) cycle();
    reset = 1'b1; epoch_pulse = 1'b1; cycle(); reset = 1'b0; epoch_pulse = 1'b0;
    chk("t5_flags", 128'({et_wr, cs_wr, cp_wr}), 128'(0));
    chk("t5_cp_zero", 128'(code_phase_init), 128'(0));
    cycle();
    chk("t5_no_done", 128'(done), 128'(0));

`ifdef TIME_INIT_PPS_ALIGN_EN
    // PPS aligned: wait for sec_pulse, then load on 2nd following epoch pulse
    request(8'd1, 3'b111, 32'h77);
    pps_align = 1'b1;
    cycle(); req = 1'b0; pps_align = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(); epoch_pulse = 1'b1; cycle(); epoch_pulse = 1'b0;
      chk("t6_wait_pps", 128'(state), 128'(3));
    end
    sec_pulse = 1'b1; epoch_pulse = 1'b1; cycle(); sec_pulse = 1'b0; epoch_pulse = 1'b0;
    chk("t6_armed", 128'(state), 128'(1));
    cycle(); epoch_pulse = 1'b1; cycle(); epoch_pulse = 1'b0;
    chk("t6_load", 128'(state), 128'(2));
    epoch_pulse = 1'b1; cycle(); epoch_pulse = 1'b0;
    chk("t6_done", 128'(done), 128'(1));
    cycle();
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req           = ($urandom_range(0, 7) == 0);
      cancel        = ($urandom_range(0, 39) == 0);
      epoch_pulse   = ($urandom_range(0, 4) == 0);
      reset         = ($urandom_range(0, 299) == 0);
      sec_pulse     = ($urandom_range(0, 9) == 0);
      pps_align     = 1'($urandom_range(0, 1));
      epoch_dly     = 8'($urandom_range(0, 3));
      load_mask     = 3'($urandom);
      code_phase_in = $urandom;
      chip_in       = 24'($urandom);
      symb_in       = 5'($urandom);
      epoch_in      = 10'($urandom);
      tow_in        = 20'($urandom);
      cycle();
    end
    req = 1'b0; cancel = 1'b0; epoch_pulse = 1'b0; reset = 1'b0; sec_pulse = 1'b0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
